// File: rtl/mio_bus_slave.sv
// Memory/IO responder behind the CPU memory handshake.
// Decodes word accesses to data RAM, an LED register, switches or nothing.
module mio_bus_slave #(
    parameter int RAM_AW  = 10,
    parameter int RAM_LAT = 1,
    parameter int LED_W   = 8,
    parameter int SW_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mio_req,
    input  logic              mem_w,
    input  logic [31:0]       addr,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              mio_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    output logic [LED_W-1:0]  led,
    input  logic [SW_W-1:0]   sw
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [1:0] SEL_RAM  = 2'd0;
    localparam logic [1:0] SEL_LED  = 2'd1;
    localparam logic [1:0] SEL_SW   = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

    localparam logic [2:0] CNT_LAST = 3'(RAM_LAT - 1);

    logic [1:0]        state;
    logic [2:0]        cnt;
    logic              w_q;
    logic [RAM_AW-1:0] addr_q;
    logic [31:0]       din_q;
    logic [SW_W-1:0]   sw_meta;
    logic [SW_W-1:0]   sw_sync;
    logic [1:0]        sel;
    logic [31:0]       periph_rd;
    logic              unused_ok;

    assign unused_ok = ^{addr[1:0], addr[27:RAM_AW+2]};

    always_comb begin
        sel = SEL_NONE;
        unique case (1'b1)
            addr[31:28] == 4'h0: sel = SEL_RAM;
            addr[31:28] == 4'hF: sel = SEL_LED;
            addr[31:28] == 4'hE: sel = SEL_SW;
            default:             sel = SEL_NONE;
        endcase
    end

    // Peripheral read data is resolved at the sampling edge.
    always_comb begin
        periph_rd = '0;
        unique case (sel)
            SEL_LED: periph_rd[LED_W-1:0] = led;
            SEL_SW:  periph_rd[SW_W-1:0]  = sw_sync;
            default: periph_rd = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            w_q      <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            data_out <= '0;
            led      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mio_req) begin
                        w_q    <= mem_w;
                        addr_q <= addr[RAM_AW+1:2];
                        din_q  <= data_in;
                        cnt    <= '0;
                        if (sel == SEL_RAM) begin
                            state <= ACCESS;
                        end else begin
                            state <= RESP;
                            if (!mem_w) begin
                                data_out <= periph_rd;
                            end else if (sel == SEL_LED) begin
                                led <= data_in[LED_W-1:0];
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (w_q) begin
                        state <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        cnt      <= '0;
                        data_out <= ram_dout;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mio_ready = (state == RESP);
    assign ram_en    = (state == ACCESS);
    assign ram_we    = ram_en & w_q;
    assign ram_addr  = addr_q;
    assign ram_din   = din_q;

endmodule

// File: tb/tb_mio_bus_slave.sv
// Directed bench for mio_bus_slave with a two-cycle-latency RAM model.
module tb_mio_bus_slave;

    localparam int RAM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mio_req = 1'b0;
    logic        mem_w = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        mio_ready;
    logic        ram_en;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic [7:0]  led;
    logic [7:0]  sw = '0;

    int nvec = 0;
    int nerr = 0;
    int we_cnt = 0;
    int rdy_cnt = 0;
    logic [9:0] last_we_addr = '0;

    logic [31:0] mem [0:1023];
    logic [31:0] rd_q;

    mio_bus_slave #(
        .RAM_AW (10),
        .RAM_LAT(RAM_LAT),
        .LED_W  (8),
        .SW_W   (8)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .mio_req  (mio_req),
        .mem_w    (mem_w),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .mio_ready(mio_ready),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .led      (led),
        .sw       (sw)
    );

    always #5 clk = ~clk;

    // Read data is only valid two cycles into an enabled read; else poison.
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_din;
        rd_q <= (ram_en && !ram_we) ? mem[ram_addr] : 32'hBAD0BAD0;
    end
    assign ram_dout = rd_q;

    always @(negedge clk) begin
        if (ram_we) begin
            we_cnt++;
            last_we_addr = ram_addr;
        end
        if (mio_ready) rdy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input string tag, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input int lat, input logic chk_rd,
                        input logic [31:0] exp_rd,
                        input logic scramble, input logic drop);
        int cyc;
        cyc = 0;
        @(negedge clk);
        mio_req = 1'b1;
        mem_w   = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
        if (scramble) begin
            addr    = ~a;
            data_in = ~d;
            mem_w   = ~w;
        end
        if (drop) mio_req = 1'b0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (mio_ready) break;
            @(posedge clk);
        end
        check({tag, "_lat"}, 32'(cyc), 32'(lat));
        if (chk_rd) check({tag, "_rd"}, data_out, exp_rd);
        mio_req = 1'b0;
        mem_w   = 1'b0;
    endtask

    initial begin
        int w0;
        int r0;
        int c;
        int first;
        int second;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_rdy", 32'(mio_ready), 32'd0);
            check("idle_en", 32'(ram_en), 32'd0);
            check("idle_led", 32'(led), 32'd0);
            check("idle_dout", data_out, 32'd0);
        end

        xfer("led_wr", 1'b1, 32'hF000_0000, 32'h0000_00A5, 1, 1'b0, '0,
             1'b0, 1'b0);
        check("led_val", 32'(led), 32'hA5);
        check("led_wr_dout", data_out, 32'd0);
        xfer("led_rd", 1'b0, 32'hF000_0000, '0, 1, 1'b1, 32'h0000_00A5,
             1'b0, 1'b0);

        w0 = we_cnt;
        xfer("ram_wr", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2, 1'b1,
             32'h0000_00A5, 1'b1, 1'b0);
        check("ram_wr_cnt", 32'(we_cnt - w0), 32'd1);
        check("ram_wr_addr", 32'(last_we_addr), 32'd4);
        check("ram_wr_mem", mem[4], 32'hDEAD_BEEF);

        w0 = we_cnt;
        xfer("ram_rd", 1'b0, 32'h0000_0010, '0, 3, 1'b1, 32'hDEAD_BEEF,
             1'b1, 1'b0);
        check("ram_rd_nowe", 32'(we_cnt - w0), 32'd0);
        xfer("ram_rd_drop", 1'b0, 32'h0000_0010, '0, 3, 1'b1,
             32'hDEAD_BEEF, 1'b0, 1'b1);

        sw = 8'h3C;
        repeat (3) @(posedge clk);
        xfer("sw_rd", 1'b0, 32'hE000_0000, '0, 1, 1'b1, 32'h0000_003C,
             1'b0, 1'b0);
        xfer("sw_wr", 1'b1, 32'hE000_0000, 32'h0000_00FF, 1, 1'b1,
             32'h0000_003C, 1'b0, 1'b0);
        check("sw_wr_led", 32'(led), 32'hA5);

        w0 = we_cnt;
        xfer("um_wr", 1'b1, 32'h8000_0000, 32'h0000_0055, 1, 1'b1,
             32'h0000_003C, 1'b0, 1'b0);
        check("um_wr_led", 32'(led), 32'hA5);
        check("um_wr_we", 32'(we_cnt - w0), 32'd0);
        check("um_wr_mem", mem[4], 32'hDEAD_BEEF);
        xfer("um_rd", 1'b0, 32'h8000_0000, '0, 1, 1'b1, 32'h0,
             1'b0, 1'b0);

        w0 = we_cnt;
        c = 0;
        first = -1;
        second = -1;
        @(negedge clk);
        mio_req = 1'b1;
        mem_w   = 1'b1;
        addr    = 32'h0000_0020;
        data_in = 32'h1111_1111;
        while (c < 30 && second < 0) begin
            @(posedge clk);
            @(negedge clk);
            c++;
            if (mio_ready) begin
                if (first < 0) begin
                    first   = c;
                    addr    = 32'h0000_0024;
                    data_in = 32'h2222_2222;
                end else begin
                    second = c;
                end
            end
        end
        mio_req = 1'b0;
        mem_w   = 1'b0;
        check("b2b_first", 32'(first), 32'd2);
        check("b2b_gap", 32'(second - first), 32'd3);
        check("b2b_we", 32'(we_cnt - w0), 32'd2);
        check("b2b_mem8", mem[8], 32'h1111_1111);
        check("b2b_mem9", mem[9], 32'h2222_2222);

        @(negedge clk);
        mio_req = 1'b1;
        mem_w   = 1'b0;
        addr    = 32'h0000_0010;
        @(posedge clk);
        @(negedge clk);
        check("rst_acc_en", 32'(ram_en), 32'd1);
        r0 = rdy_cnt;
        rst = 1'b1;
        #1;
        check("rst_en", 32'(ram_en), 32'd0);
        check("rst_rdy", 32'(mio_ready), 32'd0);
        mio_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_no_rdy", 32'(rdy_cnt - r0), 32'd0);
        check("rst_dout", data_out, 32'd0);
        xfer("post_rst_rd", 1'b0, 32'h0000_0010, '0, 3, 1'b1,
             32'hDEAD_BEEF, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
